// File: rtl/ic_fetch_unit.sv
// ic_fetch_unit: direct-mapped instruction cache with a sequential PC generator.
//
// On a hit the fetch unit sends {pc, instr} to the instruction queue (IQ)
// through registered outputs. On a miss it sends one word address to the
// memory fetcher (fc) and then waits for the instruction fill. An exception
// from the ROB redirects the PC from any state.
//
// Optional feature (macro ICACHE_FILL_FORWARD_EN): when defined, a fill that
// arrives while the IQ has room is delivered to the IQ in the same cycle as
// the array write. This saves the extra lookup cycle on each miss.
//
// Ports:
//   clk, rst                 clock (posedge), asynchronous active-low reset
//   rdy                      global ready; when low, all state and outputs freeze
//   is_exception_from_rob    redirect pulse; new_pc_from_rob is the target
//   is_ready_from_fc         fc request queue has room
//   is_commit_from_fc        fc commit pulse; is_instr_from_fc marks a fill
//   data_from_fc             instruction word carried by the fill
//   is_empty_to_fc           goes low for one cycle per miss request
//   addr_to_fc               word-aligned miss address
//   is_full_from_iq          IQ cannot accept
//   is_valid_to_iq           one-cycle delivery pulse; pc_to_iq / instr_to_iq
module ic_fetch_unit #(
  parameter int IndexBits = 6,
  parameter int PcWidth   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               is_exception_from_rob,
  input  logic [PcWidth-1:0] new_pc_from_rob,
  input  logic               is_ready_from_fc,
  input  logic               is_commit_from_fc,
  input  logic               is_instr_from_fc,
  input  logic [PcWidth-1:0] data_from_fc,
  output logic               is_empty_to_fc,
  output logic [PcWidth-1:0] addr_to_fc,
  input  logic               is_full_from_iq,
  output logic               is_valid_to_iq,
  output logic [PcWidth-1:0] pc_to_iq,
  output logic [PcWidth-1:0] instr_to_iq
);
  localparam int TagBits = PcWidth - 2 - IndexBits;
  localparam int Lines   = 1 << IndexBits;

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PcWidth-1:0]   pc_q, pc_d;
  logic [Lines-1:0]     valid_q;
  logic [TagBits-1:0]   tag_q  [Lines];
  logic [PcWidth-1:0]   data_q [Lines];

  logic [IndexBits-1:0] idx;
  logic [TagBits-1:0]   ptag;
  logic                 hit, fill;
  logic                 deliver, req, wr;
  logic [PcWidth-1:0]   dlv_instr;

  assign idx  = pc_q[IndexBits+1:2];
  assign ptag = pc_q[PcWidth-1:IndexBits+2];
  assign hit  = valid_q[idx] && (tag_q[idx] == ptag);
  assign fill = is_commit_from_fc && is_instr_from_fc;

  // Next-state and registered-output decisions. An exception overrides
  // everything, so any same-cycle fill is dropped; fc flushes on the same
  // event. Fills are not address-checked because fc returns them in order.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    deliver   = 1'b0;
    dlv_instr = data_q[idx];
    req       = 1'b0;
    wr        = 1'b0;
    if (is_exception_from_rob) begin
      pc_d    = new_pc_from_rob;
      state_d = LOOKUP;
    end else begin
      case (state_q)
        LOOKUP: begin
          if (hit) begin
            if (!is_full_from_iq) begin
              deliver = 1'b1;
              pc_d    = pc_q + PcWidth'(4);
            end
          end else begin
            state_d = MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (is_ready_from_fc) begin
            req     = 1'b1;
            state_d = MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (fill) begin
            wr      = 1'b1;
            state_d = LOOKUP;
`ifdef ICACHE_FILL_FORWARD_EN
            if (!is_full_from_iq) begin
              deliver   = 1'b1;
              dlv_instr = data_from_fc;
              pc_d      = pc_q + PcWidth'(4);
            end
`endif
          end
        end
        default: state_d = LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= LOOKUP;
      pc_q           <= '0;
      valid_q        <= '0;
      is_valid_to_iq <= 1'b0;
      is_empty_to_fc <= 1'b1;
      addr_to_fc     <= '0;
      pc_to_iq       <= '0;
      instr_to_iq    <= '0;
    end else if (rdy) begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      is_valid_to_iq <= deliver;
      is_empty_to_fc <= !req;
      if (wr) valid_q[idx] <= 1'b1;
      if (req) addr_to_fc <= {pc_q[PcWidth-1:2], 2'b00};
      if (deliver) begin
        pc_to_iq    <= pc_q;
        instr_to_iq <= dlv_instr;
      end
    end
  end

  // The tag and data arrays have no reset because valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (rdy && wr) begin
      tag_q[idx]  <= ptag;
      data_q[idx] <= data_from_fc;
    end
  end

endmodule

// File: tb/tb_ic_fetch_unit.sv
module tb_ic_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, rdy, exc, rf, cm, ins, full;
  logic [31:0] npc, dat;
  logic        empty, vld;
  logic [31:0] addr, pciq, iiq;

  ic_fetch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_exception_from_rob(exc), .new_pc_from_rob(npc),
    .is_ready_from_fc(rf), .is_commit_from_fc(cm), .is_instr_from_fc(ins),
    .data_from_fc(dat), .is_empty_to_fc(empty), .addr_to_fc(addr),
    .is_full_from_iq(full), .is_valid_to_iq(vld), .pc_to_iq(pciq),
    .instr_to_iq(iiq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Program memory seen through fc: a fixed hash of the word address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Reference cache: for each of the 64 slots, the word address it holds.
  bit          cv [64];
  logic [29:0] cw [64];

  function automatic bit mhit(input logic [31:0] a);
    int s;
    s = int'(a[7:2]);
    return cv[s] && (cw[s] == a[31:2]);
  endfunction

  typedef struct {
    logic        rdy, exc;
    logic [31:0] npc;
    logic        rf, cm, ins;
    logic [31:0] dat;
    logic        full;
    logic        ev, ee;
    logic [31:0] ea, ep, ei;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [31:0] np, logic f, logic c,
                              logic i, logic [31:0] d, logic fl, logic ev,
                              logic ee, logic [31:0] ea, logic [31:0] ep,
                              logic [31:0] ei);
    vec_t v;
    v.rdy = r; v.exc = e; v.npc = np; v.rf = f; v.cm = c; v.ins = i; v.dat = d;
    v.full = fl; v.ev = ev; v.ee = ee; v.ea = ea; v.ep = ep; v.ei = ei;
    return v;
  endfunction

  vec_t tbl[$];

  // Random-phase state
  logic [31:0] exp_pc, pend_a, np_r;
  bit          pend, e_r, c_r, i_r, r_rdy;
  int          lat, idle, ndlv;
  logic        p_vld, p_empty;
  logic [31:0] p_pc;

  initial begin
    // Directed sequence from reset; each row describes one cycle.
    // Fields: rdy exc npc rf cm ins dat full | exp: vld empty addr pc instr
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 0 miss pc0
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h0,0,0));             // 1 request 0
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 2 wait
    tbl.push_back(mk(1,0,0, 1,1,1,32'h13, 0, 0,1,0,0,0));            // 3 fill
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 1,1,0,32'h0,32'h13));        // 4 hit
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 5 miss pc4
    tbl.push_back(mk(1,1,32'h0, 1,0,0,0, 0, 0,1,0,0,0));             // 6 redirect 0
    tbl.push_back(mk(1,0,0, 1,0,0,0, 1, 0,1,0,0,0));                 // 7 IQ full
    tbl.push_back(mk(1,0,0, 1,0,0,0, 1, 0,1,0,0,0));                 // 8
    tbl.push_back(mk(1,0,0, 1,0,0,0, 1, 0,1,0,0,0));                 // 9
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 1,1,0,32'h0,32'h13));        // 10 delivered
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0, 0,1,0,0,0));                 // 11 miss pc4
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,0,0, 0,0,0,0, 0, 0,1,0,0,0));               // 12-15 fc busy
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h4,0,0));             // 16 request 4
    tbl.push_back(mk(1,0,0, 1,1,0,32'hBAD, 0, 0,1,0,0,0));           // 17 non-instr
    tbl.push_back(mk(1,1,32'h80, 1,1,1,32'hDEADBEEF, 0, 0,1,0,0,0)); // 18 exc+fill
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 19 miss 80
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h80,0,0));            // 20 request 80
    tbl.push_back(mk(1,0,0, 1,1,1,32'h11111111, 0, 0,1,0,0,0));      // 21 fill
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 1,1,0,32'h80,32'h11111111)); // 22 hit
    tbl.push_back(mk(1,1,32'h100, 1,0,0,0, 0, 0,1,0,0,0));           // 23 redirect
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 24 miss
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h100,0,0));           // 25 request
    tbl.push_back(mk(1,0,0, 1,1,1,32'h22222222, 0, 0,1,0,0,0));      // 26 fill idx0
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 1,1,0,32'h100,32'h22222222));// 27 hit
    tbl.push_back(mk(1,1,32'h0, 1,0,0,0, 0, 0,1,0,0,0));             // 28 back to 0
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 29 alias miss
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h0,0,0));             // 30 request 0
    tbl.push_back(mk(1,1,32'h4, 1,0,0,0, 0, 0,1,0,0,0));             // 31 redirect 4
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 32 still miss
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h4,0,0));             // 33 request 4
    tbl.push_back(mk(1,1,32'h80, 1,0,0,0, 0, 0,1,0,0,0));            // 34 redirect 80
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 1,1,0,32'h80,32'h11111111)); // 35 hit
    for (int k = 0; k < 3; k++)                                       // 36-38 frozen
      tbl.push_back(mk(0,1,32'h40, 1,1,1,32'h44, 0, 1,1,0,32'h80,32'h11111111));
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 39 miss 84
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h84,0,0));            // 40 pc held
    tbl.push_back(mk(1,1,32'hFFFFFFFC, 1,0,0,0, 0, 0,1,0,0,0));      // 41 redirect
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 42 miss
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'hFFFFFFFC,0,0));      // 43 request
    tbl.push_back(mk(1,0,0, 1,1,1,32'h33, 0, 0,1,0,0,0));            // 44 fill
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 1,1,0,32'hFFFFFFFC,32'h33)); // 45 hit
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,1,0,0,0));                 // 46 pc wrapped
    tbl.push_back(mk(1,0,0, 1,0,0,0, 0, 0,0,32'h0,0,0));             // 47 request 0

    rst = 1'b0; rdy = 1'b1; exc = 1'b0; npc = '0; rf = 1'b0; cm = 1'b0;
    ins = 1'b0; dat = '0; full = 1'b0;
    #12;
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc", pciq, 32'h0);
    chk("rst_instr", iiq, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      rdy = tbl[i].rdy; exc = tbl[i].exc; npc = tbl[i].npc; rf = tbl[i].rf;
      cm = tbl[i].cm; ins = tbl[i].ins; dat = tbl[i].dat; full = tbl[i].full;
      @(posedge clk); #1;
      chk($sformatf("row%0d_vld", i), 32'(vld), 32'(tbl[i].ev));
      chk($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].ee));
      if (!tbl[i].ee) chk($sformatf("row%0d_addr", i), addr, tbl[i].ea);
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_pc", i), pciq, tbl[i].ep);
        chk($sformatf("row%0d_instr", i), iiq, tbl[i].ei);
      end
    end

    // Asynchronous reset in the middle of a cycle, then the randomized run.
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", 32'(vld), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_addr", addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 64; s++) begin cv[s] = 1'b0; cw[s] = '0; end
    exp_pc = '0; pend = 1'b0; pend_a = '0; lat = 0; idle = 0; ndlv = 0;
    p_vld = vld; p_empty = empty; p_pc = pciq;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      r_rdy = ($urandom_range(0, 15) != 0);
      e_r   = r_rdy && ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 15))
        0:       np_r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
        default: np_r = 32'($urandom_range(0, 3)) * 256 + 32'($urandom_range(0, 15)) * 4
                        + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      endcase
      c_r = 1'b0; i_r = 1'b0;
      dat = $urandom;
      if (r_rdy && pend && lat == 0) begin
        c_r = 1'b1; i_r = 1'b1; dat = mem(pend_a);
      end else if ($urandom_range(0, 7) == 0) begin
        c_r = 1'b1;
      end
      rdy  = r_rdy;
      exc  = r_rdy ? e_r : ($urandom_range(0, 3) == 0);
      npc  = np_r;
      cm   = c_r; ins = i_r;
      full = ($urandom_range(0, 3) == 0);
      rf   = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;

      if (!r_rdy) begin
        chk("frz_vld", 32'(vld), 32'(p_vld));
        chk("frz_empty", 32'(empty), 32'(p_empty));
        chk("frz_pc", pciq, p_pc);
      end else begin
        if (c_r && i_r) begin
          pend = 1'b0;
          if (!e_r) begin
            cv[int'(pend_a[7:2])] = 1'b1;
            cw[int'(pend_a[7:2])] = pend_a[31:2];
          end
        end else if (pend && lat > 0) begin
          lat--;
        end
        idle++;
        if (vld) begin
          chk("dlv_on_exc", 32'(e_r), 32'h0);
          chk("dlv_iq_full", 32'(full), 32'h0);
          chk("dlv_pc", pciq, exp_pc);
          chk("dlv_instr", iiq, mem(exp_pc));
          chk("dlv_cached", 32'(mhit(exp_pc)), 32'h1);
          exp_pc = exp_pc + 32'd4;
          ndlv++;
          idle = 0;
        end
        if (!empty) begin
          chk("req_on_exc", 32'(e_r), 32'h0);
          chk("req_dup", 32'(pend), 32'h0);
          chk("req_addr", addr, {exp_pc[31:2], 2'b00});
          chk("req_miss", 32'(mhit(exp_pc)), 32'h0);
          pend = 1'b1; pend_a = addr; lat = $urandom_range(0, 3);
          idle = 0;
        end
        if (e_r) begin
          exp_pc = np_r; pend = 1'b0; idle = 0;
        end
        if (idle > 60) begin
          chk("liveness_idle", 32'(idle), 32'h0);
          idle = 0;
        end
      end
      p_vld = vld; p_empty = empty; p_pc = pciq;
    end
    chk("enough_deliveries", 32'(ndlv > 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
